roots_readout_serializer: RTL and testbench
===========================================

Name: roots_readout_serializer

Overview:
- Downstream consumer of the stage-controlled decoder wrapper's result outputs.
- On each result_valid pulse it snapshots the full roots vector and the round statistics into a capture register.
- It then streams them as a framed packet of OUT_WIDTH-bit words over a valid/ready interface to the host or readout link.
- This frees the decoder to start the next round while readout proceeds.

Parameters:
CODE_DISTANCE_X, 3, X code distance
CODE_DISTANCE_Z, 3, Z code distance
ITERATION_COUNTER_WIDTH, 8, width of iteration_counter input
OUT_WIDTH, 32, output word width; must be >= ADDRESS_WIDTH and >= 32
Derived:
- MEASUREMENT_ROUNDS = max(X,Z)
- PU_COUNT = X*Z*MEASUREMENT_ROUNDS
- ADDRESS_WIDTH = 3*clog2(MEASUREMENT_ROUNDS)
- PKT_WORDS = PU_COUNT+2

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
result_valid  in  1  one-cycle pulse: round results valid
roots  in  ADDRESS_WIDTH*PU_COUNT  root of PU i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
iteration_counter  in  ITERATION_COUNTER_WIDTH  iterations used this round
cycle_counter  in  32  cycles used this round
deadlock  in  1  round ended in deadlock
final_cardinality  in  1  final cluster cardinality flag
out_data  out  OUT_WIDTH  packet word
out_valid  out  1  word valid
out_ready  in  1  sink ready
out_last  out  1  last word of packet
busy  out  1  packet capture held / streaming
overrun_count  out  8  saturating count of dropped results

Behaviour:
- Reset: while reset==0 at a clk edge, the block returns to IDLE.
  - out_valid=0, out_last=0, busy=0, out_data=0, overrun_count=0, word index=0.
  - Reset mid-packet abandons the packet with no further words.
- FSM states IDLE, HEADER, CYCLES, ROOTS.
- IDLE: on result_valid=1, capture all inputs and go to HEADER. busy=1 from the next cycle.
  - out_valid first rises the cycle after result_valid is sampled (1-cycle latency).
- Word 0 (HEADER): bit31=deadlock, bit30=final_cardinality, bits[23:16]=iteration_counter (zero-extended/truncated to 8), bits[15:0]=PU_COUNT, remaining bits 0.
- Word 1 (CYCLES): cycle_counter, zero-extended to OUT_WIDTH.
- Words 2..PKT_WORDS-1 (ROOTS):
  - Root of PU k=idx-2, zero-extended; PU 0 first.
  - out_last=1 only on the final word.
- Handshake: a word transfers when out_valid&&out_ready.
  - While out_valid&&!out_ready, out_data and out_last hold stable.
  - out_valid never drops without a transfer.
- Word index is a clog2(PKT_WORDS+1)-bit counter; it advances on transfer only.
- Final transfer:
  - If result_valid is also 1 that cycle, capture the new results, go to HEADER and keep out_valid=1 (back-to-back, no bubble).
  - Otherwise go to IDLE with out_valid=0, busy=0.
- result_valid while busy and not on the final-transfer cycle:
  - Results are dropped; the in-flight packet is unaffected.
  - overrun_count increments, saturating at 255.
- Capture register is written only on accepted captures; it is never modified mid-packet.

Decomposition:
- Shared package holds:
  - derived localparams: MEASUREMENT_ROUNDS, PU_COUNT, ADDRESS_WIDTH, PKT_WORDS
  - header bit-position constants
  - FSM state enum type
- No sub-module is natural. The roots word mux (indexed part-select of the capture register) stays inline.

Test Plan:
1. d=3: reset low 3 cycles, then high → all outputs 0. result_valid with iteration_counter=5, cycle_counter=0x00012345, deadlock=0, final_cardinality=1, root[i]=i, out_ready=1 → 29 consecutive words. Word0=0x4005001B, word1=0x00012345, word(2+i)=i, out_last only on word 28. busy falls the cycle after.
2. Same stimulus, out_ready toggled 1,0,0,1 repeating → identical 29-word sequence; data stable throughout stalls.
3. Second result_valid at word 10 → packet 1 completes unchanged; overrun_count=1; no second packet.
4. Second result_valid on the cycle word 28 transfers with out_ready=1 → next cycle out_valid=1 with the new header; no idle cycle.
5. reset=0 during word 15 with out_ready=0 → next cycle out_valid=0, busy=0. A later result_valid yields a fresh full packet starting at word 0.
6. 300 overruns during one stalled packet → overrun_count saturates at 255.

Source files
------------

// File: rtl/roots_readout_serializer_pkg.sv
// Shared sizing helpers, header field positions and FSM state type for the
// roots readout serializer.
package roots_readout_serializer_pkg;

    function automatic int rounds_f(input int dx, input int dz);
        return (dx > dz) ? dx : dz;
    endfunction

    function automatic int pu_count_f(input int dx, input int dz);
        return dx * dz * rounds_f(dx, dz);
    endfunction

    function automatic int addr_width_f(input int dx, input int dz);
        return 3 * $clog2(rounds_f(dx, dz));
    endfunction

    // Sizes for the default d=3 configuration; the top recomputes its own from its parameters.
    localparam int MEASUREMENT_ROUNDS = rounds_f(3, 3);
    localparam int PU_COUNT           = pu_count_f(3, 3);
    localparam int ADDRESS_WIDTH      = addr_width_f(3, 3);
    localparam int PKT_WORDS          = PU_COUNT + 2;

    localparam int HDR_DEADLOCK_BIT   = 31;
    localparam int HDR_FINAL_CARD_BIT = 30;
    localparam int HDR_ITER_LSB       = 16;
    localparam int HDR_PU_LSB         = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_CYCLES,
        ST_ROOTS
    } state_t;

endpackage

// File: rtl/roots_readout_serializer.sv
// Snapshots one round of decoder results and streams it as a framed packet
// (header, cycle count, one root per PU) over a valid/ready word interface.
module roots_readout_serializer
    import roots_readout_serializer_pkg::*;
#(
    parameter int CODE_DISTANCE_X         = 3,
    parameter int CODE_DISTANCE_Z         = 3,
    parameter int ITERATION_COUNTER_WIDTH = 8,
    parameter int OUT_WIDTH               = 32
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   result_valid,
    input  logic [addr_width_f(CODE_DISTANCE_X, CODE_DISTANCE_Z)
                  * pu_count_f(CODE_DISTANCE_X, CODE_DISTANCE_Z)-1:0] roots,
    input  logic [ITERATION_COUNTER_WIDTH-1:0]     iteration_counter,
    input  logic [31:0]                            cycle_counter,
    input  logic                                   deadlock,
    input  logic                                   final_cardinality,
    output logic [OUT_WIDTH-1:0]                   out_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic                                   out_last,
    output logic                                   busy,
    output logic [7:0]                             overrun_count
);

    localparam int ADDR_W  = addr_width_f(CODE_DISTANCE_X, CODE_DISTANCE_Z);
    localparam int PU_CNT  = pu_count_f(CODE_DISTANCE_X, CODE_DISTANCE_Z);
    localparam int PKT_LEN = PU_CNT + 2;
    localparam int IDX_W   = $clog2(PKT_LEN + 1);

    state_t                     state_reg;
    logic [IDX_W-1:0]           idx_reg;
    logic [ADDR_W*PU_CNT-1:0]   cap_roots_reg;
    logic [31:0]                cap_cycles_reg;

    logic [OUT_WIDTH-1:0]       header_word;
    logic [OUT_WIDTH-1:0]       next_word;
    logic [IDX_W-1:0]           idx_next;
    logic [IDX_W-1:0]           root_idx;
    logic [ADDR_W-1:0]          root_sel;
    logic                       transfer;
    logic                       do_capture;

    // Header is built straight from the inputs so it is ready on the capture edge.
    always_comb begin
        header_word = '0;
        header_word[HDR_DEADLOCK_BIT]      = deadlock;
        header_word[HDR_FINAL_CARD_BIT]    = final_cardinality;
        header_word[HDR_ITER_LSB +: 8]     = 8'(iteration_counter);
        header_word[HDR_PU_LSB +: 16]      = 16'(PU_CNT);
    end

    assign idx_next   = idx_reg + IDX_W'(1);
    assign transfer   = out_valid && out_ready;
    assign do_capture = result_valid &&
                        ((state_reg == ST_IDLE) || (transfer && out_last));

    // Word idx_next >= 2 carries PU (idx_next-2) = (idx_reg-1); clamp keeps the select in range.
    always_comb begin
        root_idx = '0;
        if (idx_reg >= IDX_W'(1) && idx_reg <= IDX_W'(PU_CNT))
            root_idx = idx_reg - IDX_W'(1);
    end

    assign root_sel  = cap_roots_reg[int'(root_idx)*ADDR_W +: ADDR_W];
    assign next_word = (idx_next == IDX_W'(1)) ? OUT_WIDTH'(cap_cycles_reg)
                                               : OUT_WIDTH'(root_sel);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            idx_reg        <= '0;
            cap_roots_reg  <= '0;
            cap_cycles_reg <= '0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            busy           <= 1'b0;
            overrun_count  <= '0;
        end else if (do_capture) begin
            cap_roots_reg  <= roots;
            cap_cycles_reg <= cycle_counter;
            out_data       <= header_word;
            out_valid      <= 1'b1;
            out_last       <= 1'b0;
            busy           <= 1'b1;
            idx_reg        <= '0;
            state_reg      <= ST_HEADER;
        end else if (state_reg != ST_IDLE) begin
            // Results arriving mid-packet are dropped and only counted.
            if (result_valid && overrun_count != 8'hFF)
                overrun_count <= overrun_count + 8'd1;
            if (transfer) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    busy      <= 1'b0;
                    idx_reg   <= '0;
                    state_reg <= ST_IDLE;
                end else begin
                    idx_reg   <= idx_next;
                    out_data  <= next_word;
                    out_last  <= (idx_next == IDX_W'(PKT_LEN - 1));
                    state_reg <= (idx_next == IDX_W'(1)) ? ST_CYCLES : ST_ROOTS;
                end
            end
        end
    end

endmodule

// File: tb/tb_roots_readout_serializer.sv
// Randomised and directed bench for roots_readout_serializer, checked against a
// packet-queue reference model.
module tb_roots_readout_serializer;

    localparam int MR     = 3;
    localparam int PU     = 3 * 3 * MR;
    localparam int AW     = 3 * $clog2(MR);
    localparam int PKT    = PU + 2;
    localparam int ROOTSW = AW * PU;

    logic              clk = 1'b0;
    logic              reset;
    logic              result_valid;
    logic [ROOTSW-1:0] roots;
    logic [7:0]        iteration_counter;
    logic [31:0]       cycle_counter;
    logic              deadlock;
    logic              final_cardinality;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic [7:0]        overrun_count;

    roots_readout_serializer dut (
        .clk               (clk),
        .reset             (reset),
        .result_valid      (result_valid),
        .roots             (roots),
        .iteration_counter (iteration_counter),
        .cycle_counter     (cycle_counter),
        .deadlock          (deadlock),
        .final_cardinality (final_cardinality),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_last          (out_last),
        .busy              (busy),
        .overrun_count     (overrun_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: queue of words still owed to the sink.
    logic [31:0] exp_q[$];
    int remaining   = 0;
    int exp_overrun = 0;
    int xfer_total  = 0;
    bit after_reset = 0;

    function automatic void push_packet();
        logic [ROOTSW-1:0] tmp;
        exp_q.push_back({deadlock, final_cardinality, 6'd0, iteration_counter, 16'(PU)});
        exp_q.push_back(cycle_counter);
        for (int k = 0; k < PU; k++) begin
            tmp = roots >> (k * AW);
            exp_q.push_back(32'(tmp[AW-1:0]));
        end
    endfunction

    always @(negedge clk) begin
        bit xfer;
        bit accept;
        check("out_valid", out_valid, remaining > 0);
        check("busy", busy, remaining > 0);
        check("overrun", overrun_count, exp_overrun);
        if (remaining > 0) begin
            check("out_data", out_data, exp_q[0]);
            check("out_last", out_last, remaining == 1);
        end else begin
            check("out_last_idle", out_last, 0);
        end
        if (after_reset) begin
            check("out_data_rst", out_data, 0);
            after_reset = 0;
        end
        if (!reset) begin
            exp_q.delete();
            remaining   = 0;
            exp_overrun = 0;
            after_reset = 1;
        end else begin
            xfer   = (remaining > 0) && out_ready;
            accept = result_valid && (remaining == 0 || (remaining == 1 && xfer));
            if (xfer) begin
                void'(exp_q.pop_front());
                remaining--;
                xfer_total++;
            end
            if (result_valid) begin
                if (accept) begin
                    push_packet();
                    remaining += PKT;
                end else if (exp_overrun < 255) begin
                    exp_overrun++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        result_valid = 1'b1;
        step();
        result_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        repeat (n) step();
        reset = 1'b1;
        step();
    endtask

    task automatic set_directed(input logic [7:0] it);
        for (int i = 0; i < PU; i++) roots[i*AW +: AW] = AW'(i);
        iteration_counter = it;
        cycle_counter     = 32'h0001_2345;
        deadlock          = 1'b0;
        final_cardinality = 1'b1;
    endtask

    task automatic set_random();
        for (int i = 0; i < PU; i++) roots[i*AW +: AW] = AW'($urandom);
        iteration_counter = 8'($urandom);
        cycle_counter     = $urandom;
        deadlock          = 1'($urandom);
        final_cardinality = 1'($urandom);
    endtask

    // mode 0: always ready, 1: pattern 1,0,0,1, 2: random
    task automatic drain(input int mode);
        int c = 0;
        while (remaining > 0 && c < 2000) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 4 == 0) || (c % 4 == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            step();
            c++;
        end
        if (remaining > 0) check("drain_timeout", 1, 0);
        out_ready = 1'b1;
        step();
    endtask

    task automatic wait_words(input int n);
        int start = xfer_total;
        int c = 0;
        while (xfer_total - start < n && c < 500) begin
            step();
            c++;
        end
        if (xfer_total - start < n) check("wait_timeout", 1, 0);
    endtask

    initial begin
        reset = 1'b0;
        result_valid = 1'b0;
        out_ready = 1'b1;
        roots = '0;
        iteration_counter = '0;
        cycle_counter = '0;
        deadlock = 1'b0;
        final_cardinality = 1'b0;
        do_reset(3);

        // 1: full packet, sink always ready
        set_directed(8'd5);
        pulse();
        drain(0);

        // 2: same packet through a stalling sink
        out_ready = 1'b1;
        pulse();
        drain(1);

        // 3: overrun mid-packet is dropped and counted
        do_reset(1);
        pulse();
        wait_words(10);
        set_directed(8'd9);
        pulse();
        drain(0);
        check("overrun_t3", overrun_count, 1);
        repeat (3) step();

        // 4: back-to-back capture on the final transfer
        set_directed(8'd5);
        pulse();
        begin
            int c = 0;
            while (remaining != 1 && c < 200) begin step(); c++; end
            if (remaining != 1) check("t4_timeout", 1, 0);
        end
        set_directed(8'd77);
        pulse();
        check("t4_no_bubble", out_valid, 1);
        drain(0);

        // 5: reset mid-packet with a stalled sink
        set_directed(8'd5);
        pulse();
        wait_words(15);
        out_ready = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        check("t5_busy", busy, 0);
        out_ready = 1'b1;
        pulse();
        drain(0);

        // 6: overrun counter saturation
        do_reset(1);
        out_ready = 1'b0;
        pulse();
        result_valid = 1'b1;
        repeat (300) step();
        result_valid = 1'b0;
        step();
        check("overrun_sat", overrun_count, 255);
        drain(0);

        // Random traffic
        do_reset(1);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 80; c++) begin
                set_random();
                out_ready    = 1'($urandom_range(0, 1));
                result_valid = ($urandom_range(0, 9) == 0);
                step();
            end
            result_valid = 1'b0;
            drain(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
